// File: rtl/ex_stage_ex_mem.sv
// rtl/ex_stage_ex_mem.sv - RV64 execute stage with operand forwarding, branch resolve and EX/MEM register
// Optional feature macro: EX_FORWARDING_EN (EX/MEM and MEM/WB operand forwarding)
module ex_stage_ex_mem #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_ex_regwrite,
    input  logic            id_ex_memtoreg,
    input  logic            id_ex_branch,
    input  logic            id_ex_memwrite,
    input  logic            id_ex_memread,
    input  logic            id_ex_alusrc,
    input  logic [1:0]      id_ex_aluop,
    input  logic [XLEN-1:0] id_ex_pc,
    input  logic [XLEN-1:0] id_ex_rdata1,
    input  logic [XLEN-1:0] id_ex_rdata2,
    input  logic [XLEN-1:0] id_ex_imm,
    input  logic [3:0]      id_ex_funct,
    input  logic [4:0]      id_ex_rs1,
    input  logic [4:0]      id_ex_rs2,
    input  logic [4:0]      id_ex_rd,
    input  logic            mem_wb_regwrite,
    input  logic [4:0]      mem_wb_rd,
    input  logic [XLEN-1:0] mem_wb_wdata,
    input  logic            stall,
    input  logic            flush,
    output logic            ex_branch_taken,
    output logic [XLEN-1:0] ex_branch_target,
    output logic            ex_mem_regwrite,
    output logic            ex_mem_memtoreg,
    output logic            ex_mem_memwrite,
    output logic            ex_mem_memread,
    output logic [XLEN-1:0] ex_mem_alu_result,
    output logic [XLEN-1:0] ex_mem_wdata,
    output logic [4:0]      ex_mem_rd,
    output logic            ex_mem_zero
);

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

    logic            r_regwrite;
    logic            r_memtoreg;
    logic            r_memwrite;
    logic            r_memread;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_wdata;
    logic [4:0]      r_rd;
    logic            r_zero;

    logic [XLEN-1:0] w_fwd_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_result;
    logic [3:0]      w_funct_eff;
    logic [5:0]      w_shamt;
    logic [2:0]      w_f3;
    alu_op_t         w_alu_op;
    logic            w_taken;

    assign w_f3 = id_ex_funct[2:0];

`ifdef EX_FORWARDING_EN
    // EX/MEM is the younger producer, so it is checked first.
    always_comb begin
        w_fwd_a = id_ex_rdata1;
        if (r_regwrite && (r_rd != 5'd0) && (r_rd == id_ex_rs1))
            w_fwd_a = r_alu_result;
        else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs1))
            w_fwd_a = mem_wb_wdata;
    end

    always_comb begin
        w_fwd_b = id_ex_rdata2;
        if (r_regwrite && (r_rd != 5'd0) && (r_rd == id_ex_rs2))
            w_fwd_b = r_alu_result;
        else if (mem_wb_regwrite && (mem_wb_rd != 5'd0) && (mem_wb_rd == id_ex_rs2))
            w_fwd_b = mem_wb_wdata;
    end
`else
    logic w_unused_mem_wb;
    assign w_unused_mem_wb = mem_wb_regwrite ^ (^mem_wb_rd) ^ (^mem_wb_wdata)
                           ^ (^id_ex_rs1) ^ (^id_ex_rs2);
    assign w_fwd_a = id_ex_rdata1;
    assign w_fwd_b = id_ex_rdata2;
`endif

    assign w_alu_b = id_ex_alusrc ? id_ex_imm : w_fwd_b;
    assign w_shamt = w_alu_b[5:0];

    // I-type only honours funct7[5] for shifts, so addi with imm[10] set never subtracts.
    always_comb begin
        w_funct_eff = id_ex_funct;
        if (id_ex_aluop == 2'b11 && w_f3 != 3'b001 && w_f3 != 3'b101)
            w_funct_eff = {1'b0, w_f3};
    end

    always_comb begin
        w_alu_op = ALU_ADD;
        case (id_ex_aluop)
            2'b00: w_alu_op = ALU_ADD;
            2'b01: w_alu_op = ALU_SUB;
            default: begin
                case (w_funct_eff)
                    4'b0000: w_alu_op = ALU_ADD;
                    4'b1000: w_alu_op = ALU_SUB;
                    4'b0001: w_alu_op = ALU_SLL;
                    4'b0100: w_alu_op = ALU_XOR;
                    4'b0101: w_alu_op = ALU_SRL;
                    4'b1101: w_alu_op = ALU_SRA;
                    4'b0110: w_alu_op = ALU_OR;
                    4'b0111: w_alu_op = ALU_AND;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
        endcase
    end

    always_comb begin
        w_alu_result = w_fwd_a + w_alu_b;
        case (w_alu_op)
            ALU_ADD: w_alu_result = w_fwd_a + w_alu_b;
            ALU_SUB: w_alu_result = w_fwd_a - w_alu_b;
            ALU_SLL: w_alu_result = w_fwd_a << w_shamt;
            ALU_XOR: w_alu_result = w_fwd_a ^ w_alu_b;
            ALU_SRL: w_alu_result = w_fwd_a >> w_shamt;
            ALU_SRA: w_alu_result = $signed(w_fwd_a) >>> w_shamt;
            ALU_OR:  w_alu_result = w_fwd_a | w_alu_b;
            ALU_AND: w_alu_result = w_fwd_a & w_alu_b;
            default: w_alu_result = w_fwd_a + w_alu_b;
        endcase
    end

    // Branch compares always use the register operands, never the immediate.
    always_comb begin
        w_taken = 1'b0;
        case (w_f3)
            3'b000:  w_taken = (w_fwd_a == w_fwd_b);
            3'b001:  w_taken = (w_fwd_a != w_fwd_b);
            3'b100:  w_taken = ($signed(w_fwd_a) <  $signed(w_fwd_b));
            3'b101:  w_taken = ($signed(w_fwd_a) >= $signed(w_fwd_b));
            3'b110:  w_taken = (w_fwd_a <  w_fwd_b);
            3'b111:  w_taken = (w_fwd_a >= w_fwd_b);
            default: w_taken = 1'b0;
        endcase
    end

    assign ex_branch_taken  = id_ex_branch & w_taken;
    assign ex_branch_target = id_ex_pc + id_ex_imm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_alu_result <= '0;
            r_wdata      <= '0;
            r_rd         <= 5'd0;
            r_zero       <= 1'b0;
        end else if (flush) begin
            r_regwrite   <= 1'b0;
            r_memtoreg   <= 1'b0;
            r_memwrite   <= 1'b0;
            r_memread    <= 1'b0;
            r_alu_result <= '0;
            r_wdata      <= '0;
            r_rd         <= 5'd0;
            r_zero       <= 1'b0;
        end else if (!stall) begin
            r_regwrite   <= id_ex_regwrite;
            r_memtoreg   <= id_ex_memtoreg;
            r_memwrite   <= id_ex_memwrite;
            r_memread    <= id_ex_memread;
            r_alu_result <= w_alu_result;
            r_wdata      <= w_fwd_b;
            r_rd         <= id_ex_rd;
            r_zero       <= (w_alu_result == '0);
        end
    end

    assign ex_mem_regwrite   = r_regwrite;
    assign ex_mem_memtoreg   = r_memtoreg;
    assign ex_mem_memwrite   = r_memwrite;
    assign ex_mem_memread    = r_memread;
    assign ex_mem_alu_result = r_alu_result;
    assign ex_mem_wdata      = r_wdata;
    assign ex_mem_rd         = r_rd;
    assign ex_mem_zero       = r_zero;

endmodule

// File: tb/tb_ex_stage_ex_mem.sv
// tb/tb_ex_stage_ex_mem.sv - directed vector bench for ex_stage_ex_mem
module tb_ex_stage_ex_mem;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_ex_regwrite, id_ex_memtoreg, id_ex_branch, id_ex_memwrite, id_ex_memread, id_ex_alusrc;
    logic [1:0]  id_ex_aluop;
    logic [63:0] id_ex_pc, id_ex_rdata1, id_ex_rdata2, id_ex_imm;
    logic [3:0]  id_ex_funct;
    logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
    logic        mem_wb_regwrite;
    logic [4:0]  mem_wb_rd;
    logic [63:0] mem_wb_wdata;
    logic        stall, flush;
    logic        ex_branch_taken;
    logic [63:0] ex_branch_target;
    logic        ex_mem_regwrite, ex_mem_memtoreg, ex_mem_memwrite, ex_mem_memread;
    logic [63:0] ex_mem_alu_result, ex_mem_wdata;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_zero;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ex_stage_ex_mem #(.XLEN(64)) dut (
        .clk(clk), .reset(reset),
        .id_ex_regwrite(id_ex_regwrite), .id_ex_memtoreg(id_ex_memtoreg),
        .id_ex_branch(id_ex_branch), .id_ex_memwrite(id_ex_memwrite),
        .id_ex_memread(id_ex_memread), .id_ex_alusrc(id_ex_alusrc),
        .id_ex_aluop(id_ex_aluop), .id_ex_pc(id_ex_pc),
        .id_ex_rdata1(id_ex_rdata1), .id_ex_rdata2(id_ex_rdata2),
        .id_ex_imm(id_ex_imm), .id_ex_funct(id_ex_funct),
        .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
        .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
        .mem_wb_wdata(mem_wb_wdata), .stall(stall), .flush(flush),
        .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
        .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
        .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_memread(ex_mem_memread),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_wdata(ex_mem_wdata),
        .ex_mem_rd(ex_mem_rd), .ex_mem_zero(ex_mem_zero)
    );

    typedef struct {
        string       name;
        logic        branch, regwrite, memtoreg, memwrite, memread, alusrc;
        logic [1:0]  aluop;
        logic [3:0]  funct;
        logic [63:0] pc, a, b, imm;
        logic [4:0]  rd;
        logic [63:0] exp_res;
        logic        exp_zero, exp_taken;
        logic [63:0] exp_target;
    } vec_t;

    localparam int NV = 22;
    vec_t v [NV];

    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M2 = 64'hFFFF_FFFF_FFFF_FFFE;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        id_ex_regwrite = 1'b0; id_ex_memtoreg = 1'b0; id_ex_branch = 1'b0;
        id_ex_memwrite = 1'b0; id_ex_memread = 1'b0; id_ex_alusrc = 1'b0;
        id_ex_aluop = 2'b00; id_ex_funct = 4'h0;
        id_ex_pc = '0; id_ex_rdata1 = '0; id_ex_rdata2 = '0; id_ex_imm = '0;
        id_ex_rs1 = 5'd0; id_ex_rs2 = 5'd0; id_ex_rd = 5'd0;
        mem_wb_regwrite = 1'b0; mem_wb_rd = 5'd0; mem_wb_wdata = '0;
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_add(input logic [4:0] rd, input logic [63:0] a);
        idle_inputs();
        id_ex_regwrite = 1'b1; id_ex_rd = rd; id_ex_rdata1 = a;
        tick();
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".regwrite"}, {63'd0, ex_mem_regwrite}, 64'd0);
        chk({nm, ".memtoreg"}, {63'd0, ex_mem_memtoreg}, 64'd0);
        chk({nm, ".memwrite"}, {63'd0, ex_mem_memwrite}, 64'd0);
        chk({nm, ".memread"},  {63'd0, ex_mem_memread},  64'd0);
        chk({nm, ".rd"},       {59'd0, ex_mem_rd},       64'd0);
    endtask

    initial begin
        //       name     br    rw    mt    mw    mr    as    op     fn     pc          a                      b            imm                    rd     res                    z     t     target
        v[0]  = '{"add",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 64'h0,   64'd5,                 64'd7,       64'h0,                 5'd3,  64'd12,                1'b0, 1'b0, 64'h0};
        v[1]  = '{"sub01",1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h0, 64'h0,   64'd7,                 64'd7,       64'h0,                 5'd4,  64'd0,                 1'b1, 1'b0, 64'h0};
        v[2]  = '{"subR", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'h8, 64'h0,   64'd5,                 64'd7,       64'h0,                 5'd5,  M2,                    1'b0, 1'b0, 64'h0};
        v[3]  = '{"sll",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'h1, 64'h0,   64'd1,                 64'h44,      64'h0,                 5'd6,  64'd16,                1'b0, 1'b0, 64'h0};
        v[4]  = '{"sra",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'hD, 64'h0,   64'h8000_0000_0000_0000, 64'd4,     64'h0,                 5'd7,  64'hF800_0000_0000_0000, 1'b0, 1'b0, 64'h0};
        v[5]  = '{"srl",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'h5, 64'h0,   64'h8000_0000_0000_0000, 64'd4,     64'h0,                 5'd7,  64'h0800_0000_0000_0000, 1'b0, 1'b0, 64'h0};
        v[6]  = '{"xor",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'h4, 64'h0,   64'hF0,                64'hFF,      64'h0,                 5'd8,  64'h0F,                1'b0, 1'b0, 64'h0};
        v[7]  = '{"or",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'h6, 64'h0,   64'hF0,                64'h0F,      64'h0,                 5'd8,  64'hFF,                1'b0, 1'b0, 64'h0};
        v[8]  = '{"and",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'h7, 64'h0,   64'hF0,                64'h3C,      64'h0,                 5'd8,  64'h30,                1'b0, 1'b0, 64'h0};
        v[9]  = '{"addi", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'h8, 64'h0,   64'd10,                64'd99,      64'd3,                 5'd8,  64'd13,                1'b0, 1'b0, 64'h0};
        v[10] = '{"srai", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 4'hD, 64'h0,   64'hFFFF_FFFF_FFFF_FFF8, 64'd0,     64'd1,                 5'd9,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 64'h0};
        v[11] = '{"beq",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h0, 64'h100, 64'd9,                 64'd9,       64'h20,                5'd0,  64'd0,                 1'b1, 1'b1, 64'h120};
        v[12] = '{"blt",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h4, 64'h200, M1,                    64'd1,       64'hFFFF_FFFF_FFFF_FFF8, 5'd0, M2,                    1'b0, 1'b1, 64'h1F8};
        v[13] = '{"bltu", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h6, 64'h200, M1,                    64'd1,       64'h8,                 5'd0,  M2,                    1'b0, 1'b0, 64'h208};
        v[14] = '{"bne",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h1, 64'h0,   64'd5,                 64'd5,       64'h4,                 5'd0,  64'd0,                 1'b1, 1'b0, 64'h4};
        v[15] = '{"br010",1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h2, 64'h0,   64'd1,                 64'd2,       64'h0,                 5'd0,  M1,                    1'b0, 1'b0, 64'h0};
        v[16] = '{"nobr", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 4'h0, 64'h0,   64'd9,                 64'd9,       64'h0,                 5'd9,  64'd18,                1'b0, 1'b0, 64'h0};
        v[17] = '{"bge",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h5, 64'h40,  64'd1,                 M1,          64'h10,                5'd0,  64'd2,                 1'b0, 1'b1, 64'h50};
        v[18] = '{"bgeu", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 4'h7, 64'h40,  64'd1,                 M1,          64'h10,                5'd0,  64'd2,                 1'b0, 1'b0, 64'h50};
        v[19] = '{"ld",   1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 4'h3, 64'h0,   64'h2000,              64'd0,       64'h10,                5'd10, 64'h2010,              1'b0, 1'b0, 64'h0};
        v[20] = '{"f1001",1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'h9, 64'h0,   64'd3,                 64'd4,       64'h0,                 5'd11, 64'd7,                 1'b0, 1'b0, 64'h0};
        v[21] = '{"sd",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 4'h3, 64'h0,   64'h100,               64'h55,      64'h8,                 5'd0,  64'h108,               1'b0, 1'b0, 64'h0};

        idle_inputs();
        reset = 1'b1;
        #2;
        chk_all_zero("reset");
        chk("reset.result", ex_mem_alu_result, 64'd0);
        tick();
        tick();
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            idle_inputs();
            id_ex_branch = v[i].branch; id_ex_regwrite = v[i].regwrite;
            id_ex_memtoreg = v[i].memtoreg; id_ex_memwrite = v[i].memwrite;
            id_ex_memread = v[i].memread; id_ex_alusrc = v[i].alusrc;
            id_ex_aluop = v[i].aluop; id_ex_funct = v[i].funct;
            id_ex_pc = v[i].pc; id_ex_rdata1 = v[i].a; id_ex_rdata2 = v[i].b;
            id_ex_imm = v[i].imm; id_ex_rd = v[i].rd;
            #1;
            chk({v[i].name, ".taken"}, {63'd0, ex_branch_taken}, {63'd0, v[i].exp_taken});
            if (v[i].branch) chk({v[i].name, ".target"}, ex_branch_target, v[i].exp_target);
            tick();
            chk({v[i].name, ".result"},   ex_mem_alu_result, v[i].exp_res);
            chk({v[i].name, ".zero"},     {63'd0, ex_mem_zero},     {63'd0, v[i].exp_zero});
            chk({v[i].name, ".rd"},       {59'd0, ex_mem_rd},       {59'd0, v[i].rd});
            chk({v[i].name, ".regwrite"}, {63'd0, ex_mem_regwrite}, {63'd0, v[i].regwrite});
            chk({v[i].name, ".memtoreg"}, {63'd0, ex_mem_memtoreg}, {63'd0, v[i].memtoreg});
            chk({v[i].name, ".memwrite"}, {63'd0, ex_mem_memwrite}, {63'd0, v[i].memwrite});
            chk({v[i].name, ".memread"},  {63'd0, ex_mem_memread},  {63'd0, v[i].memread});
            chk({v[i].name, ".wdata"},    ex_mem_wdata,             v[i].b);
        end

        // EX/MEM and MEM/WB both target x1; the EX/MEM value must win.
        load_add(5'd1, 64'd100);
        idle_inputs();
        id_ex_regwrite = 1'b1; id_ex_alusrc = 1'b1; id_ex_aluop = 2'b11;
        id_ex_rs1 = 5'd1; id_ex_rdata1 = 64'd20; id_ex_imm = 64'd1; id_ex_rd = 5'd2;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd1; mem_wb_wdata = 64'd50;
        tick();
`ifdef EX_FORWARDING_EN
        chk("fwd_exmem.result", ex_mem_alu_result, 64'd101);
`else
        chk("nofwd.result", ex_mem_alu_result, 64'd21);
`endif

        // x0 is never forwarded.
        load_add(5'd0, 64'd100);
        idle_inputs();
        id_ex_regwrite = 1'b1; id_ex_alusrc = 1'b1; id_ex_aluop = 2'b11;
        id_ex_rs1 = 5'd0; id_ex_rdata1 = 64'd20; id_ex_imm = 64'd1; id_ex_rd = 5'd2;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd0; mem_wb_wdata = 64'd50;
        tick();
        chk("fwd_x0.result", ex_mem_alu_result, 64'd21);

        // Store with rs2 coming from MEM/WB.
        load_add(5'd1, 64'd7);
        idle_inputs();
        id_ex_memwrite = 1'b1; id_ex_alusrc = 1'b1; id_ex_imm = 64'd8;
        id_ex_rs1 = 5'd3; id_ex_rdata1 = 64'h1000; id_ex_rs2 = 5'd2; id_ex_rdata2 = 64'h1111;
        mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd2; mem_wb_wdata = 64'hDEAD;
        tick();
        chk("sd_fwd.result", ex_mem_alu_result, 64'h1008);
        chk("sd_fwd.memwrite", {63'd0, ex_mem_memwrite}, 64'd1);
`ifdef EX_FORWARDING_EN
        chk("sd_fwd.wdata", ex_mem_wdata, 64'hDEAD);
`else
        chk("sd_fwd.wdata", ex_mem_wdata, 64'h1111);
`endif

        // Stall holds for two edges, then flush beats stall.
        load_add(5'd3, 64'd12);
        idle_inputs();
        id_ex_regwrite = 1'b0; id_ex_memwrite = 1'b1; id_ex_rd = 5'd9; id_ex_rdata1 = 64'd77;
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk("stall.result", ex_mem_alu_result, 64'd12);
            chk("stall.rd", {59'd0, ex_mem_rd}, 64'd3);
            chk("stall.regwrite", {63'd0, ex_mem_regwrite}, 64'd1);
            chk("stall.memwrite", {63'd0, ex_mem_memwrite}, 64'd0);
        end
        flush = 1'b1;
        tick();
        chk_all_zero("flush_stall");

        // Asynchronous reset between edges.
        load_add(5'd4, 64'd33);
        chk("prereset.rd", {59'd0, ex_mem_rd}, 64'd4);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("reset_mid");
        chk("reset_mid.result", ex_mem_alu_result, 64'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("after_reset.rd", {59'd0, ex_mem_rd}, 64'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
